// File: rtl/face_mask_overlay.sv
// -----------------------------------------------------------------------------
// face_mask_overlay
//
// Streaming compositor for the output end of a face-detection core. It joins
// the original pixel stream with the per-pixel face-mask bit stream (both in
// raster order) and emits the composited tile. Every pixel whose mask bit is
// set is replaced by MARK_VALUE, which draws the detection rectangles. One
// square tile of side x side pixels is processed per accepted start.
//
// Optional feature macro: FACE_OVERLAY_COUNT_EN
//   When defined, the block adds a 32-bit mark_count output. It counts the
//   marked pixels of the current tile.
//
// Parameters
//   PIX_W       pixel width in bits
//   MARK_VALUE  value substituted on marked pixels (truncated to PIX_W)
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   start, side           begin a tile of side x side pixels (IDLE only, side != 0)
//   pix_valid/ready/data  original pixel stream
//   mask_valid/ready/bit  face-mask stream, one bit per pixel
//   out_valid/ready/data  composited pixel stream
//   out_row_end           out_data is the last pixel of a row
//   out_last              out_data is the last pixel of the tile
//   busy                  tile in progress (RUN or FLUSH)
//   done                  one-cycle pulse after the final output handshake
//   mark_count            marked pixels in this tile (FACE_OVERLAY_COUNT_EN only)
// -----------------------------------------------------------------------------
module face_mask_overlay #(
  parameter int PIX_W      = 8,
  parameter int MARK_VALUE = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      side,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  input  logic             mask_valid,
  input  logic             mask_bit,
  output logic             mask_ready,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_data,
  input  logic             out_ready,
  output logic             out_row_end,
  output logic             out_last,
`ifdef FACE_OVERLAY_COUNT_EN
  output logic [31:0]      mark_count,
`endif
  output logic             busy,
  output logic             done
);

  localparam logic [PIX_W-1:0] MARK_PIX = PIX_W'(MARK_VALUE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [15:0]      side_q;
  logic [15:0]      col;
  logic [15:0]      row;
  logic             col_last;
  logic             row_last;
  logic             space;
  logic             take;
  logic             start_ok;
  logic             final_hs;

  logic             vld_p0;
  logic [PIX_W-1:0] data_p0;
  logic             row_end_p0;
  logic             last_p0;
  logic             done_q;

  // Replace a pixel with the marker colour when it lies on a face border.
  function automatic logic [PIX_W-1:0] composite(input logic [PIX_W-1:0] pix,
                                                 input logic             mark);
    composite = mark ? MARK_PIX : pix;
  endfunction

  // The output register can accept a new pair when it is empty or is being
  // drained in this same cycle. Back-to-back transfers therefore need no bubble.
  assign space      = !vld_p0 || out_ready;
  assign pix_ready  = (state == RUN) && mask_valid && space;
  assign mask_ready = (state == RUN) && pix_valid && space;

  // A pair is consumed only when both streams present data together.
  // A lone valid on either side consumes nothing.
  assign take     = pix_valid && pix_ready;
  assign start_ok = (state == IDLE) && start && (side != 16'd0);
  assign final_hs = (state == FLUSH) && vld_p0 && out_ready && last_p0;

  assign col_last = (col == side_q - 16'd1);
  assign row_last = (row == side_q - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (take && col_last && row_last) state_next = FLUSH;
      FLUSH:   if (final_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tile geometry and raster position. The counters wrap to zero on the last
  // pixel of the tile, so they never exceed side-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      side_q <= 16'd0;
      col    <= 16'd0;
      row    <= 16'd0;
    end else if (start_ok) begin
      side_q <= side;
      col    <= 16'd0;
      row    <= 16'd0;
    end else if (final_hs) begin
      col    <= 16'd0;
      row    <= 16'd0;
    end else if (take) begin
      if (col_last) begin
        col <= 16'd0;
        row <= row_last ? 16'd0 : row + 16'd1;
      end else begin
        col <= col + 16'd1;
      end
    end
  end

  // ---- stage p0: composited output register ----
  // The reset clears the data bits as well, so a mid-tile reset shows
  // all-zero outputs right away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0     <= 1'b0;
      data_p0    <= '0;
      row_end_p0 <= 1'b0;
      last_p0    <= 1'b0;
    end else if (take) begin
      vld_p0     <= 1'b1;
      data_p0    <= composite(pix_data, mask_bit);
      row_end_p0 <= col_last;
      last_p0    <= col_last && row_last;
    end else if (out_ready) begin
      vld_p0     <= 1'b0;
    end
  end

  // done is registered. It pulses in the same cycle that the state returns
  // to IDLE, so busy falls together with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= final_hs;
    end
  end

`ifdef FACE_OVERLAY_COUNT_EN
  logic [31:0] mark_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mark_cnt_q <= 32'd0;
    end else if (start_ok) begin
      mark_cnt_q <= 32'd0;
    end else if (take && mask_bit) begin
      mark_cnt_q <= mark_cnt_q + 32'd1;
    end
  end

  assign mark_count = mark_cnt_q;
`endif

  assign out_valid   = vld_p0;
  assign out_data    = data_p0;
  assign out_row_end = row_end_p0;
  assign out_last    = last_p0;
  assign busy        = (state != IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_face_mask_overlay.sv
// -----------------------------------------------------------------------------
// tb_face_mask_overlay
//
// Scoreboard bench for face_mask_overlay. When the bench sees an input pair
// being accepted, it pushes the expected composited pixel. A negedge monitor
// pops and compares each output handshake and also tracks the done pulse.
// -----------------------------------------------------------------------------
module tb_face_mask_overlay;

  localparam int PIX_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      side;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic             pix_ready;
  logic             mask_valid;
  logic             mask_bit;
  logic             mask_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;
  logic             out_ready;
  logic             out_row_end;
  logic             out_last;
  logic             busy;
  logic             done;
`ifdef FACE_OVERLAY_COUNT_EN
  logic [31:0]      mark_count;
`endif

  always #5 clk = ~clk;

  face_mask_overlay #(.PIX_W(PIX_W), .MARK_VALUE(255)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .side        (side),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .mask_valid  (mask_valid),
    .mask_bit    (mask_bit),
    .mask_ready  (mask_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .out_row_end (out_row_end),
    .out_last    (out_last),
`ifdef FACE_OVERLAY_COUNT_EN
    .mark_count  (mark_count),
`endif
    .busy        (busy),
    .done        (done)
  );

  typedef struct packed {
    logic [PIX_W-1:0] data;
    logic             row_end;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   exp_marks = 0;
  logic done_due  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Output monitor: samples at negedge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      done_due = 1'b0;
    end else begin
      check("done", 32'(done), 32'(done_due));
      if (done_due) check("busy_fall", 32'(busy), 0);
      done_due = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'(out_valid), 0);
        end else begin
          e = sb.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_row_end", 32'(out_row_end), 32'(e.row_end));
          check("out_last", 32'(out_last), 32'(e.last));
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  // All tasks are entered and left at posedge+1.
  task automatic start_tile(input int s);
    side  = 16'(s);
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    exp_marks = 0;
    check("busy_rise", 32'(busy), 1);
  endtask

  task automatic send_tile(input int s, input logic [15:0] mask, input int base,
                           input int skew, input int abort_at, input int dup_start_at);
    int n   = s * s;
    int idx = 0;
    int cyc = 0;
    while (idx < n && idx != abort_at && cyc < 400) begin
      pix_valid  = 1'b1;
      pix_data   = 8'(base + idx);
      mask_valid = (cyc >= skew);
      mask_bit   = mask[idx];
      start      = (cyc == dup_start_at);
      if (cyc == dup_start_at) side = 16'd5;
      @(negedge clk);
      if (!mask_valid) check("skew_no_take", 32'(pix_ready), 0);
      if (pix_valid && pix_ready && mask_valid && mask_ready) begin
        sb.push_back(exp_t'{data:    (mask[idx] ? 8'd255 : 8'(base + idx)),
                            row_end: ((idx % s) == s - 1),
                            last:    (idx == n - 1)});
        if (mask[idx]) exp_marks++;
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid  = 1'b0;
    mask_valid = 1'b0;
    start      = 1'b0;
    if (idx < n && idx != abort_at) check("input_timeout", 32'(idx), 32'(n));
  endtask

  task automatic finish_tile(input string tag);
    int i = 0;
    while ((sb.size() != 0 || done_due) && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (i >= 200) check({tag, "_drain"}, 32'(sb.size()), 0);
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(busy), 0);
`ifdef FACE_OVERLAY_COUNT_EN
    check({tag, "_mark_count"}, mark_count, 32'(exp_marks));
`endif
  endtask

  task automatic stall(input logic [PIX_W-1:0] first_pix);
    int i = 0;
    while (!out_valid && i < 50) begin
      @(posedge clk); #1;
      i++;
    end
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 1);
      check("bp_hold", 32'(out_data), 32'(first_pix));
      check("bp_pix_rdy", 32'(pix_ready), 0);
      check("bp_mask_rdy", 32'(mask_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_row_end"}, 32'(out_row_end), 0);
    check({tag, "_last"}, 32'(out_last), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pix_ready"}, 32'(pix_ready), 0);
    check({tag, "_mask_ready"}, 32'(mask_ready), 0);
`ifdef FACE_OVERLAY_COUNT_EN
    check({tag, "_mark_count"}, mark_count, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    side       = 16'd0;
    pix_valid  = 1'b0;
    pix_data   = '0;
    mask_valid = 1'b0;
    mask_bit   = 1'b0;
    out_ready  = 1'b1;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 3x3 tile, a single marked pixel in the centre
    start_tile(3);
    send_tile(3, 16'h0010, 10, 0, -1, -1);
    finish_tile("t3x3");

    // Backpressure on the first output of a 2x2 tile
    start_tile(2);
    fork
      send_tile(2, 16'h0000, 20, 0, -1, -1);
      stall(8'd20);
    join
    finish_tile("bp");

    // Mask stream lags the pixel stream by 4 cycles
    start_tile(2);
    send_tile(2, 16'h0005, 30, 4, -1, -1);
    finish_tile("skew");

    // side = 0 is ignored
    side      = 16'd0;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    pix_valid  = 1'b1;
    mask_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("z_busy", 32'(busy), 0);
      check("z_pix_ready", 32'(pix_ready), 0);
      check("z_mask_ready", 32'(mask_ready), 0);
      @(posedge clk); #1;
    end
    pix_valid  = 1'b0;
    mask_valid = 1'b0;

    // A second start (side = 5) during RUN must not disturb the 2x2 geometry
    start_tile(2);
    send_tile(2, 16'h0008, 40, 0, -1, 1);
    finish_tile("dup");

    // Reset after 5 of 16 pixels, then a clean 4x4 tile
    start_tile(4);
    send_tile(4, 16'h0000, 50, 0, 5, -1);
    reset = 1'b1;
    #1;
    check_all_zero("midrst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    start_tile(4);
    send_tile(4, 16'h8001, 60, 0, -1, -1);
    finish_tile("t4x4");

    // Single-pixel tile
    start_tile(1);
    send_tile(1, 16'h0001, 7, 0, -1, -1);
    finish_tile("t1x1");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
